// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the transmitter state type.
package uart_pkg;
  localparam int OVERSAMPLE = 8;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_hold.sv
// uart_tx_hold: one-entry holding register with valid/ready on both sides.
module uart_tx_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  logic full;
  assign in_ready = ~full;
  assign out_valid = full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      out_data <= 8'h00;
    end else begin
      if (in_valid && in_ready) out_data <= in_data;
      full <= (in_valid && in_ready) || (full && !out_ready);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter driven by an 8x baud tick, LSB first.
// Define UART_TX_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudtick8,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  uart_tx_state_t state, state_n;
  logic [2:0] tick_cnt, bit_cnt;
  logic stop_cnt;
  logic [7:0] shift;
  logic bit_end, frame_end, load;
  logic [7:0] load_data;
  assign bit_end = baudtick8 && tick_cnt == 3'(OVERSAMPLE - 1);
  assign frame_end = bit_end && state == STOP && stop_cnt == 1'(STOP_BITS - 1);
  assign tx_busy = state != IDLE;
`ifdef UART_TX_BUF_EN
  logic hold_valid, hold_ready, hold_pop, direct;
  logic [7:0] hold_data;
  // An idle transmitter with an empty holder takes the byte straight into the shifter.
  assign direct = tx_valid && tx_ready && state == IDLE && !hold_valid;
  assign hold_pop = hold_valid && (state == IDLE || frame_end);
  assign load = direct || hold_pop;
  assign load_data = hold_pop ? hold_data : tx_data;
  assign tx_ready = hold_ready;
  uart_tx_hold u_hold (
    .clk(clk),
    .reset(reset),
    .in_data(tx_data),
    .in_valid(tx_valid && !(state == IDLE && !hold_valid)),
    .in_ready(hold_ready),
    .out_data(hold_data),
    .out_valid(hold_valid),
    .out_ready(hold_pop)
  );
`else
  logic ready_q;
  assign tx_ready = ready_q;
  assign load = tx_valid && ready_q;
  assign load_data = tx_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b1;
    else ready_q <= state_n == IDLE;
  end
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = load ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = (bit_end && bit_cnt == 3'(DATA_BITS - 1)) ? STOP : DATA;
      STOP:    state_n = frame_end ? (load ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Ticks seen in IDLE never count, so a tick coincident with acceptance is skipped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= 3'd0;
      bit_cnt <= 3'd0;
      stop_cnt <= 1'b0;
      shift <= 8'h00;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (baudtick8 && state != IDLE) begin
        tick_cnt <= tick_cnt + 3'd1;
        tx <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      end
      if (bit_end && state == DATA) bit_cnt <= bit_cnt + 3'd1;
      if (bit_end && state == STOP) stop_cnt <= frame_end ? 1'b0 : stop_cnt + 1'b1;
      if (load) shift <= load_data;
      else if (bit_end && state == DATA) shift <= shift >> 1;
    end
  end
endmodule
